ser_tx: RTL
===========

Name:
ser_tx

Overview:
- Asynchronous-serial transmitter that turns a parallel byte into a UART-style frame: one start bit (0), WIDTH data bits LSB-first, one stop bit (1).
- Fixed CLKS_PER_BIT clocks per bit time.
- Drive side of the sequential library's serial link: the upstream stage presents a word with a start/ready handshake, and the block owns the line until the frame ends.

Parameters:
- WIDTH, 8, number of data bits per frame (1..16).
- CLKS_PER_BIT, 4, clock cycles per bit time (>=1); the internal bit-timer width is sized with clog2.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  reset, asynchronous, active-low (0 = reset).
- start  input  1  request to send din; sampled only when ready=1.
- din  input  WIDTH  parallel data word; captured on the edge that accepts start.
- ready  output  1  1 = idle and able to accept start.
- busy  output  1  1 while a frame is on the line (start, data or stop bit).
- txd  output  1  serial line; idles high.
- done  output  1  single-cycle pulse marking frame completion.

Behaviour:
- Interface: one clock (clk); rst is asynchronous and active-low.
- Reset:
  - rst=0 forces, immediately and independently of clk: txd=1, ready=1, busy=0, done=0, state=IDLE.
  - The bit timer, bit counter and shift register clear to 0.
  - Reset mid-frame aborts the frame; txd returns high without waiting for the stop bit.
- Outputs: all are registered; no combinational path from start/din to any output.
- States: IDLE, START, DATA, STOP.
- IDLE:
  - txd=1, busy=0, ready=1.
  - If start=1 on a rising edge: capture din into the shift register, clear the bit timer, go to START.
  - On that same edge: txd<=0, busy<=1, ready<=0.
- START:
  - txd=0 for CLKS_PER_BIT cycles.
  - When the timer reaches CLKS_PER_BIT-1: go to DATA, drive shift[0] onto txd, clear the bit counter.
- DATA:
  - Each bit is held for CLKS_PER_BIT cycles.
  - At the end of each bit time: shift right; bit counter +1.
  - After bit index WIDTH-1 completes: go to STOP with txd<=1.
- STOP:
  - txd=1 for CLKS_PER_BIT cycles.
  - Then go to IDLE with busy<=0, ready<=1, done<=1.
- done:
  - High for exactly one cycle, coincident with the first IDLE cycle.
  - Otherwise 0.
- Frame length: (WIDTH+2)*CLKS_PER_BIT cycles, measured from the accepting edge to the edge that raises done.
- Back-to-back: start=1 during the done cycle is accepted. The next start bit begins on that edge, so there are zero idle bit times between frames.
- start while ready=0 is ignored and is not queued. din changes during a frame have no effect.
- CLKS_PER_BIT=1: every bit lasts one cycle; the timer is degenerate but the frame format is unchanged.
- Bit timer and bit counter never wrap mid-frame; both reset to 0 at each state transition that starts a new bit.

Test Plan:
- Reset: hold rst=0 for 3 cycles with start=1, din=8'hFF -> txd=1, ready=1, busy=0, done=0 throughout; no frame starts.
- Single frame (WIDTH=8, CLKS_PER_BIT=4): start pulse with din=8'hA5 -> txd bit sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles. busy=1 for 40 cycles. done=1 for one cycle at cycle 40 after the accepting edge, with ready=1 in that cycle.
- Back-to-back: din=8'h00 then din=8'hFF, second start asserted in the done cycle -> two 40-cycle frames with no idle gap. txd is low for 36 consecutive cycles (start + 8 zeros), then the stop bit high, then the second frame's start bit low.
- Busy rejection: mid-frame (cycle 12) pulse start with din=8'h3C -> the frame in progress is unchanged; after done, ready=1 and no second frame starts.
- Async reset mid-frame: assert rst=0 between clock edges during DATA bit 3 -> txd=1, busy=0, ready=1 before the next edge. After release, start with din=8'h5A -> a clean, complete frame.
- CLKS_PER_BIT=1, WIDTH=4: din=4'b0110 -> txd=0,0,1,1,0,1 on consecutive cycles; done at cycle 6.

Source files
------------

// File: rtl/ser_tx.sv
// UART-style serial transmitter: start bit (0), WIDTH data bits LSB-first,
// stop bit (1), each bit held for CLKS_PER_BIT clocks. All outputs are registered.
module ser_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  output logic             ready,
  output logic             busy,
  output logic             txd,
  output logic             done
);

  // Timer and counter keep at least one bit so the degenerate cases stay legal.
  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BIT_LAST   = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state, state_nxt;
  logic [TW-1:0]     timer, timer_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic [WIDTH-1:0]  shift, shift_nxt;
  logic              txd_nxt, busy_nxt, ready_nxt, done_nxt;
  logic              bit_end;

  assign bit_end = (timer == TIMER_LAST);

  // State and output registers; reset aborts any frame and idles the line high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      timer <= '0;
      cnt   <= '0;
      shift <= '0;
      txd   <= 1'b1;
      busy  <= 1'b0;
      ready <= 1'b1;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
      cnt   <= cnt_nxt;
      shift <= shift_nxt;
      txd   <= txd_nxt;
      busy  <= busy_nxt;
      ready <= ready_nxt;
      done  <= done_nxt;
    end
  end

  // Next-state logic: bit timing, LSB-first shifting and the completion pulse.
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    cnt_nxt   = cnt;
    shift_nxt = shift;
    txd_nxt   = txd;
    busy_nxt  = busy;
    ready_nxt = ready;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = START;
          shift_nxt = din;
          timer_nxt = '0;
          txd_nxt   = 1'b0;
          busy_nxt  = 1'b1;
          ready_nxt = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_nxt = DATA;
          timer_nxt = '0;
          cnt_nxt   = '0;
          txd_nxt   = shift[0];
        end else begin
          timer_nxt = timer + TW'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          timer_nxt = '0;
          shift_nxt = shift >> 1;
          if (cnt == BIT_LAST) begin
            state_nxt = STOP;
            txd_nxt   = 1'b1;
          end else begin
            cnt_nxt = cnt + CW'(1);
            txd_nxt = shift_nxt[0];
          end
        end else begin
          timer_nxt = timer + TW'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          state_nxt = IDLE;
          timer_nxt = '0;
          txd_nxt   = 1'b1;
          busy_nxt  = 1'b0;
          ready_nxt = 1'b1;
          done_nxt  = 1'b1;
        end else begin
          timer_nxt = timer + TW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        txd_nxt   = 1'b1;
        busy_nxt  = 1'b0;
        ready_nxt = 1'b1;
      end
    endcase
  end

endmodule
